sram_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single SRAM port of the SLC-3. It sits between the SRAM pins and two masters: the CPU memory path (MAR address, MDR data, driven by the state controller) and a program loader / debug port. It shares the port between them, drives SRAM address, data and strobes for a fixed number of wait cycles, captures read data, and returns a one-cycle completion pulse to the granted requester.

---
 rtl/sram_port_arbiter.sv | 93 +++++++++
 tb/tb_sram_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares the single SLC-3 SRAM port between the CPU memory path and the loader/debug port
//   Clk, Reset          clock, synchronous active-high reset
//   cpu_* / ldr_*       per-requester req/we/addr/wdata in, ready pulse and held rdata out
//   sram_*              SRAM address, write data, read data, oe/we strobes (active-high)
//   grant               current or last owner (0 = CPU, 1 = loader)
//   WAIT_CYCLES (1..15) cycles strobes and address are held per access
//   SRAM_ARB_CPU_PRIORITY_EN defined: CPU wins ties; undefined: round-robin on ties
module sram_port_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [15:0] cpu_rdata,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_ready,
    output logic [15:0] ldr_rdata,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        grant
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic pick_ldr, sel_we;
    logic [15:0] sel_addr, sel_wdata;
`ifdef SRAM_ARB_CPU_PRIORITY_EN
    assign pick_ldr = ldr_req & ~cpu_req;
`else
    // on a tie the loader wins only if the CPU owned the port last
    assign pick_ldr = ldr_req & (~cpu_req | ~grant);
`endif
    always_comb begin
        sel_we    = pick_ldr ? ldr_we    : cpu_we;
        sel_addr  = pick_ldr ? ldr_addr  : cpu_addr;
        sel_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
    end
    // the SRAM pin registers double as the latched copy of the granted operands
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            grant      <= 1'b1;
            sram_addr  <= 16'd0;
            sram_wdata <= 16'd0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            cpu_ready  <= 1'b0;
            ldr_ready  <= 1'b0;
            cpu_rdata  <= 16'd0;
            ldr_rdata  <= 16'd0;
        end else begin
            case (state)
                IDLE: if (cpu_req | ldr_req) begin
                    state      <= ACCESS;
                    cnt        <= 4'(WAIT_CYCLES - 1);
                    grant      <= pick_ldr;
                    sram_addr  <= sel_addr;
                    sram_wdata <= sel_wdata;
                    sram_oe    <= ~sel_we;
                    sram_we    <= sel_we;
                end
                ACCESS: if (cnt == 4'd0) begin
                    state     <= DONE;
                    sram_oe   <= 1'b0;
                    sram_we   <= 1'b0;
                    cpu_ready <= ~grant;
                    ldr_ready <= grant;
                    if (sram_oe && grant) ldr_rdata <= sram_rdata;
                    if (sram_oe && !grant) cpu_rdata <= sram_rdata;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b0;
                    ldr_ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: self-checking bench for sram_port_arbiter against a transaction-level model
module tb_sram_port_arbiter;
    localparam int W = 2;
`ifdef SRAM_ARB_CPU_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    logic        Clk = 1'b0, Reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
    logic        cpu_ready, ldr_ready, sram_oe, sram_we, grant;
    logic [15:0] cpu_rdata, ldr_rdata, sram_addr, sram_wdata, sram_rdata;
    logic        u_cpu_req = 0, u_cpu_ready, u_ldr_ready, u_sram_oe, u_sram_we, u_grant;
    logic [15:0] u_cpu_addr = 0, u_cpu_rdata, u_ldr_rdata, u_sram_addr, u_sram_wdata, u_sram_rdata;
    logic [15:0] mem [64];
    logic [15:0] exp_crd = 0, exp_lrd = 0;
    bit last = 1'b1;
    int errs = 0, checks = 0;

    always #5 Clk = ~Clk;
    assign sram_rdata   = mem[sram_addr[5:0]];
    assign u_sram_rdata = mem[u_sram_addr[5:0]];

    sram_port_arbiter #(.WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ready(ldr_ready), .ldr_rdata(ldr_rdata),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_oe(sram_oe), .sram_we(sram_we), .grant(grant)
    );

    sram_port_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(u_cpu_req), .cpu_we(1'b0), .cpu_addr(u_cpu_addr), .cpu_wdata(16'h0000),
        .cpu_ready(u_cpu_ready), .cpu_rdata(u_cpu_rdata),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(16'h0000), .ldr_wdata(16'h0000),
        .ldr_ready(u_ldr_ready), .ldr_rdata(u_ldr_rdata),
        .sram_addr(u_sram_addr), .sram_wdata(u_sram_wdata), .sram_rdata(u_sram_rdata),
        .sram_oe(u_sram_oe), .sram_we(u_sram_we), .grant(u_grant)
    );

    // arbitration rule: lone requester wins; tie goes to CPU (priority) or to the non-last owner
    function automatic bit pick(input bit c, input bit l);
        pick = !c ? 1'b1 : !l ? 1'b0 : PRIO ? 1'b0 : !last;
    endfunction

    // one full access by owner o, starting in the IDLE cycle where its request is visible
    task automatic serve(input bit o, input bit we, input logic [15:0] a, input logic [15:0] wd, input bit pert);
        last = o;
        @(posedge Clk);
        for (int k = 0; k < W; k++) begin
            @(negedge Clk);
            checks++;
            if ({sram_addr, sram_oe, sram_we, cpu_ready, ldr_ready, grant} !== {a, !we, we, 2'b00, o}) begin
                errs++;
                $display("FAIL access%0d: got addr=%h oe=%b we=%b rdy=%b%b grant=%b, want addr=%h oe=%b we=%b rdy=00 grant=%b",
                         k, sram_addr, sram_oe, sram_we, cpu_ready, ldr_ready, grant, a, !we, we, o);
            end
            if (we) begin
                checks++;
                if (sram_wdata !== wd) begin
                    errs++;
                    $display("FAIL wdata%0d: got %h want %h", k, sram_wdata, wd);
                end
            end
            if (pert && k == 0) begin
                if (o) begin ldr_addr = a ^ 16'h0030; ldr_we = !we; ldr_wdata = ~wd; end
                else   begin cpu_addr = a ^ 16'h0030; cpu_we = !we; cpu_wdata = ~wd; end
            end
        end
        if (!we && o) exp_lrd = mem[a[5:0]];
        if (!we && !o) exp_crd = mem[a[5:0]];
        @(negedge Clk);
        checks++;
        if ({cpu_ready, ldr_ready, sram_oe, sram_we} !== {!o, o, 2'b00}) begin
            errs++;
            $display("FAIL done: got rdy=%b%b oe=%b we=%b, want rdy=%b%b oe=0 we=0",
                     cpu_ready, ldr_ready, sram_oe, sram_we, !o, o);
        end
        checks++;
        if ({cpu_rdata, ldr_rdata} !== {exp_crd, exp_lrd}) begin
            errs++;
            $display("FAIL rdata: got cpu=%h ldr=%h want cpu=%h ldr=%h", cpu_rdata, ldr_rdata, exp_crd, exp_lrd);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic serve_owner(input bit o, input bit pert);
        if (o) serve(1'b1, ldr_we, ldr_addr, ldr_wdata, pert);
        else   serve(1'b0, cpu_we, cpu_addr, cpu_wdata, pert);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({sram_oe, sram_we, sram_addr, sram_wdata, cpu_ready, ldr_ready, cpu_rdata, ldr_rdata, grant} !==
            {2'b00, 32'h0, 2'b00, 32'h0, 1'b1}) begin
            errs++;
            $display("FAIL %s: got oe=%b we=%b addr=%h wd=%h rdy=%b%b crd=%h lrd=%h grant=%b, want all 0 grant=1",
                     tag, sram_oe, sram_we, sram_addr, sram_wdata, cpu_ready, ldr_ready, cpu_rdata, ldr_rdata, grant);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset");
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check_reset_outputs("post_reset_idle");
        @(posedge Clk); #1;
    endtask

    task automatic test_cpu_read;
        mem[6'h10] = 16'h1234;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        serve_owner(pick(1, 0), 1'b0);
        cpu_req = 0;
    endtask

    task automatic test_ldr_write;
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h3000; ldr_wdata = 16'hBEEF;
        serve_owner(pick(0, 1), 1'b0);
        ldr_req = 0;
    endtask

    task automatic test_tie;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'($urandom); ldr_wdata = 16'($urandom);
        for (int n = 0; n < 4; n++) serve_owner(pick(1, 1), 1'b0);
        cpu_req = 0; ldr_req = 0;
    endtask

    task automatic test_operand_change;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        serve_owner(pick(1, 0), 1'b1);
        cpu_req = 0;
    endtask

    task automatic test_reset_mid;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0011;
        @(posedge Clk);
        @(posedge Clk); #1;
        Reset = 1; cpu_req = 0;
        @(posedge Clk); #1;
        Reset = 0;
        exp_crd = 0; exp_lrd = 0; last = 1'b1;
        @(negedge Clk);
        check_reset_outputs("reset_mid");
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++;
            if ({cpu_ready, ldr_ready, sram_oe, sram_we} !== 4'b0000) begin
                errs++;
                $display("FAIL reset_mid_quiet%0d: got rdy=%b%b oe=%b we=%b want 0000", k, cpu_ready, ldr_ready, sram_oe, sram_we);
            end
        end
        @(posedge Clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0022;
        serve_owner(pick(1, 0), 1'b0);
        cpu_req = 0;
    endtask

    task automatic test_random;
        bit c, l, o;
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
            c = 1'($urandom); l = 1'($urandom);
            if (!c && !l) c = 1;
            cpu_req = c; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            ldr_req = l; ldr_we = 1'($urandom); ldr_addr = 16'($urandom); ldr_wdata = 16'($urandom);
            o = pick(c, l);
            serve_owner(o, $urandom_range(0, 3) == 0);
            if (o) ldr_req = 0; else cpu_req = 0;
            if (c && l) begin
                serve_owner(!o, 1'b0);
                if (o) cpu_req = 0; else ldr_req = 0;
            end
        end
    endtask

    task automatic test_wait1;
        logic [15:0] a;
        a = 16'($urandom);
        u_cpu_addr = a; u_cpu_req = 1;
        @(posedge Clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            checks++;
            if ({u_cpu_ready, u_sram_oe, u_ldr_ready} !== {c % 3 == 2, c % 3 == 1, 1'b0}) begin
                errs++;
                $display("FAIL wait1 cyc%0d: got rdy=%b oe=%b lrdy=%b want rdy=%b oe=%b lrdy=0",
                         c, u_cpu_ready, u_sram_oe, u_ldr_ready, c % 3 == 2, c % 3 == 1);
            end
            if (c % 3 == 2) begin
                checks++;
                if (u_cpu_rdata !== mem[a[5:0]]) begin
                    errs++;
                    $display("FAIL wait1_rdata cyc%0d: got %h want %h", c, u_cpu_rdata, mem[a[5:0]]);
                end
            end
        end
        u_cpu_req = 0;
        @(posedge Clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        test_reset;
        test_cpu_read;
        test_ldr_write;
        test_tie;
        test_operand_change;
        test_reset_mid;
        test_random;
        test_wait1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
